// File: rtl/demux_pkg.sv
// Shared constants, state encoding and index decode for demux1to32_stream.
package demux_pkg;

    localparam int unsigned NUM_DEST = 32;
    localparam int unsigned SEL_W    = 5;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic logic [NUM_DEST-1:0] onehot(input logic [SEL_W-1:0] sel);
        onehot      = '0;
        onehot[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/demux1to32_stream_sat_cnt16.sv
// 16-bit saturating event counter; only built when DEMUX_DROP_CNT_EN is defined.
`ifdef DEMUX_DROP_CNT_EN
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 16'd1;
        end
    end

endmodule
`endif

// File: rtl/demux1to32_stream.sv
// One-word stream demultiplexer to 32 destinations with per-destination enable.
// Optional DEMUX_DROP_CNT_EN adds a saturating drop_cnt output.
module demux1to32_stream
    import demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic [NUM_DEST-1:0]   dest_en,
    output logic [NUM_DEST-1:0]   out_valid,
    input  logic [NUM_DEST-1:0]   out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  drop
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [15:0]           drop_cnt
`endif
);

    state_t           state;
    logic [SEL_W-1:0] hsel;
    logic             accept;
    logic             load;
    logic             complete;

    // A FULL slot frees itself this cycle when its destination is ready.
    assign in_ready = (state == EMPTY) || out_ready[hsel];
    assign accept   = in_valid && in_ready;
    assign load     = accept && dest_en[in_sel];
    assign complete = (state == FULL) && out_ready[hsel];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            hsel      <= '0;
            out_data  <= '0;
            out_valid <= '0;
            drop      <= 1'b0;
        end else begin
            drop <= accept && !dest_en[in_sel];
            if (load) begin
                state     <= FULL;
                hsel      <= in_sel;
                out_data  <= in_data;
                out_valid <= onehot(in_sel);
            end else if (complete) begin
                state     <= EMPTY;
                out_valid <= '0;
            end
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    sat_cnt16 u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop),
        .count (drop_cnt)
    );
`endif

endmodule

// File: tb/tb_demux1to32_stream.sv
// Scoreboard bench for demux1to32_stream: directed scenarios plus random traffic.
module tb_demux1to32_stream;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_sel;
    logic [31:0] dest_en;
    logic [31:0] out_valid;
    logic [31:0] out_ready;
    logic [31:0] out_data;
    logic        drop;
`ifdef DEMUX_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    item_t       q[$];
    bit          exp_drop = 1'b0;
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    demux1to32_stream #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .dest_en   (dest_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop      (drop)
`ifdef DEMUX_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a single-entry buffer; words enter when the buffer is
    // (or is about to become) empty, disabled destinations yield a drop.
    always @(posedge clk) begin
        if (mon_en) begin
            if (rst) begin
                q.delete();
                exp_drop = 1'b0;
                exp_cnt  = '0;
            end else begin
                if (exp_drop && exp_cnt != 16'hFFFF) exp_cnt++;
                exp_drop = 1'b0;
                if (in_valid && q.size() == 0) begin
                    if (dest_en[in_sel]) q.push_back('{sel: in_sel, data: in_data});
                    else exp_drop = 1'b1;
                end
            end
        end
    end

    // Monitor: compares presented outputs against the queue head and retires
    // it when the destination accepts on the coming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_ready;
            if (q.size() == 0) exp_ready = 1'b1;
            else               exp_ready = out_ready[q[0].sel];
            check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
            check("drop", {31'b0, drop}, {31'b0, exp_drop});
`ifdef DEMUX_DROP_CNT_EN
            check("drop_cnt", {16'b0, drop_cnt}, {16'b0, exp_cnt});
`endif
            if (q.size() == 0) begin
                check("out_valid_idle", out_valid, 32'h0);
            end else begin
                check("out_valid", out_valid, 32'h1 << q[0].sel);
                check("out_data", out_data, q[0].data);
                if (out_ready[q[0].sel] && !rst) void'(q.pop_front());
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        dest_en   = '1;
        out_ready = '1;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("rst_drop", {31'b0, drop}, 32'h0);

        // single transfer
        in_valid = 1'b1; in_sel = 5'd7; in_data = 32'hA5A5_0007;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("single_valid", out_valid, 32'h0000_0080);
        check("single_data", out_data, 32'hA5A5_0007);
        step();

        // back-to-back
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_sel = 5'(3 + i); in_data = 32'hB0B0_0000 + 32'(i);
            step();
            @(negedge clk);
            check("b2b_valid", out_valid, 32'h1 << (3 + i));
            check("b2b_ready", {31'b0, in_ready}, 32'h1);
        end
        in_valid = 1'b0;
        step();

        // backpressure on destination 2, with a word waiting for dest 6
        out_ready = '1; out_ready[2] = 1'b0;
        in_valid = 1'b1; in_sel = 5'd2; in_data = 32'hC0DE_0002;
        step();
        in_sel = 5'd6; in_data = 32'hC0DE_0006;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'b0, in_ready}, 32'h0);
            check("bp_data", out_data, 32'hC0DE_0002);
            check("bp_valid", out_valid, 32'h0000_0004);
            step();
        end
        out_ready[2] = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {31'b0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid", out_valid, 32'h0000_0040);
        check("bp_next_data", out_data, 32'hC0DE_0006);
        step();

        // drop on disabled destination 9
        dest_en[9] = 1'b0;
        in_valid = 1'b1; in_sel = 5'd9; in_data = 32'hDEAD_0009;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("drop_pulse", {31'b0, drop}, 32'h1);
        check("drop_no_valid", out_valid, 32'h0);
        step();
        @(negedge clk);
        check("drop_end", {31'b0, drop}, 32'h0);
`ifdef DEMUX_DROP_CNT_EN
        check("drop_cnt_one", {16'b0, drop_cnt}, 32'h1);
        in_valid = 1'b1;
        repeat (70000) step();
        in_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check("drop_cnt_sat", {16'b0, drop_cnt}, 32'h0000_FFFF);
`endif
        dest_en = '1;
        step();

        // reset while holding a word for destination 31
        out_ready[31] = 1'b0;
        in_valid = 1'b1; in_sel = 5'd31; in_data = 32'h3131_3131;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("hold31_valid", out_valid, 32'h8000_0000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", out_valid, 32'h0);
        check("midrst_data", out_data, 32'h0);
        check("midrst_ready", {31'b0, in_ready}, 32'h1);
        check("midrst_drop", {31'b0, drop}, 32'h0);
        out_ready = '1;

        // random traffic
        repeat (3000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 5'($urandom_range(0, 31));
            in_data  = $urandom;
            for (int b = 0; b < 32; b++) begin
                dest_en[b]   = ($urandom_range(0, 7) != 0);
                out_ready[b] = ($urandom_range(0, 9) < 7);
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = '1;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
